// File: rtl/psum_seq_pkg.sv
// Shared definitions for the partial-sum SRAM sequencer: default widths,
// command opcodes and the sequencer state encoding.
package psum_seq_pkg;

    localparam int DW_DEF    = 36;
    localparam int AW_DEF    = 12;
    localparam int LANES_DEF = 4;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_ACC   = 2'b01;
    localparam logic [1:0] OP_DRAIN = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        ACC_RD    = 3'd2,
        ACC_WR    = 3'd3,
        DRAIN_RD  = 3'd4,
        DRAIN_OUT = 3'd5,
        DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/psum_sram_sequencer_if.sv
// Bus between the sequencer and the partial-sum SRAM wrapper.
// The sequencer is the master; the SRAM wrapper (or its model) is the slave.
interface psum_sram_sequencer_if #(
    parameter int DW    = 36,
    parameter int AW    = 12,
    parameter int LANES = 4
) ();

    logic                  ps_sram_cen_n;
    logic                  ps_sram_wen_n;
    logic                  ps_sram_rst_en;
    logic [AW-1:0]         ps_sram_addr;
    logic [LANES*DW-1:0]   ps_sram_wr_data;
    logic [LANES*DW-1:0]   ps_sram_rd_data;

    modport master (
        output ps_sram_cen_n,
        output ps_sram_wen_n,
        output ps_sram_rst_en,
        output ps_sram_addr,
        output ps_sram_wr_data,
        input  ps_sram_rd_data
    );

    modport slave (
        input  ps_sram_cen_n,
        input  ps_sram_wen_n,
        input  ps_sram_rst_en,
        input  ps_sram_addr,
        input  ps_sram_wr_data,
        output ps_sram_rd_data
    );

endinterface

// File: rtl/psum_sram_sequencer_lane_adder.sv
// One lane of the read-modify-write adder: signed DW-bit add.
// With PS_SAT_EN defined the result clamps to the signed range and a
// saturation indication is produced; otherwise it wraps.
module psum_lane_adder #(
    parameter int DW = 36
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
`ifdef PS_SAT_EN
    output logic          sat,
`endif
    output logic [DW-1:0] sum
);

    logic [DW-1:0] raw_s;

`ifdef PS_SAT_EN
    logic ovf_s;

    // Overflow only when both operands share a sign the raw result lost.
    always_comb begin
        raw_s = a + b;
        ovf_s = (a[DW-1] == b[DW-1]) && (raw_s[DW-1] != a[DW-1]);
        if (ovf_s) begin
            if (a[DW-1]) begin
                sum = {1'b1, {(DW-1){1'b0}}};
            end else begin
                sum = {1'b0, {(DW-1){1'b1}}};
            end
        end else begin
            sum = raw_s;
        end
        sat = ovf_s;
    end
`else
    // Plain two's-complement wrap.
    always_comb begin
        raw_s = a + b;
        sum   = raw_s;
    end
`endif

endmodule

// File: rtl/psum_sram_sequencer.sv
// Command-driven sequencer for the 4-bank partial-sum SRAM group.
// Operations: CLEAR (zero-fill), ACCUMULATE (read-modify-write of PE
// partial sums, 1 element per 2 cycles) and DRAIN (stream sums out).
// Optional build macro PS_SAT_EN: saturating lane adds plus a sticky
// per-command sat_flag output.
module psum_sram_sequencer
    import psum_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [AW-1:0]       cmd_base,
    input  logic [AW-1:0]       cmd_len_m1,
    input  logic                psum_valid,
    output logic                psum_ready,
    input  logic [LANES*DW-1:0] psum_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_data,
    psum_sram_sequencer_if.master sram,
`ifdef PS_SAT_EN
    output logic                sat_flag,
`endif
    output logic                busy,
    output logic                done
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [AW-1:0]        base_r;
    logic [AW-1:0]        len_m1_r;
    logic [AW-1:0]        idx_r;
    logic [LANES*DW-1:0]  psum_r;
    logic [LANES*DW-1:0]  sum_s;

    logic                 accept_s;
    logic                 idx_inc_s;
    logic                 psum_take_s;
    logic                 last_s;
    logic                 cen_n_s;
    logic                 wen_n_s;
    logic                 rst_en_s;
    logic                 psum_ready_s;
    logic                 out_valid_s;

    // One adder per lane: SRAM read data plus the registered partial sum.
`ifdef PS_SAT_EN
    logic [LANES-1:0]     lane_sat_s;
    logic                 sat_flag_r;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        psum_lane_adder #(.DW(DW)) u_add (
            .a   (sram.ps_sram_rd_data[i*DW +: DW]),
            .b   (psum_r[i*DW +: DW]),
`ifdef PS_SAT_EN
            .sat (lane_sat_s[i]),
`endif
            .sum (sum_s[i*DW +: DW])
        );
    end

    // State register; an async reset aborts any operation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch, element index and captured partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r   <= {AW{1'b0}};
            len_m1_r <= {AW{1'b0}};
            idx_r    <= {AW{1'b0}};
            psum_r   <= {(LANES*DW){1'b0}};
        end else begin
            if (accept_s) begin
                base_r   <= cmd_base;
                len_m1_r <= cmd_len_m1;
                idx_r    <= {AW{1'b0}};
            end else if (idx_inc_s) begin
                idx_r    <= idx_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                idx_r    <= idx_r;
            end
            if (psum_take_s) begin
                psum_r <= psum_data;
            end else begin
                psum_r <= psum_r;
            end
        end
    end

`ifdef PS_SAT_EN
    // Sticky saturation flag, cleared when a new command is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_r <= 1'b0;
        end else if (accept_s) begin
            sat_flag_r <= 1'b0;
        end else if ((state_r == ACC_WR) && (|lane_sat_s)) begin
            sat_flag_r <= 1'b1;
        end else begin
            sat_flag_r <= sat_flag_r;
        end
    end

    assign sat_flag = sat_flag_r;
`endif

    // Next-state decode and per-state SRAM/handshake controls.
    always_comb begin
        state_nxt_s  = state_r;
        accept_s     = 1'b0;
        idx_inc_s    = 1'b0;
        psum_take_s  = 1'b0;
        cen_n_s      = 1'b1;
        wen_n_s      = 1'b1;
        rst_en_s     = 1'b0;
        psum_ready_s = 1'b0;
        out_valid_s  = 1'b0;
        last_s       = (idx_r == len_m1_r);
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    case (cmd_op)
                        OP_CLEAR: state_nxt_s = CLEAR;
                        OP_ACC:   state_nxt_s = ACC_RD;
                        OP_DRAIN: state_nxt_s = DRAIN_RD;
                        default:  state_nxt_s = DONE;
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CLEAR: begin
                cen_n_s   = 1'b0;
                wen_n_s   = 1'b0;
                rst_en_s  = 1'b1;
                idx_inc_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CLEAR;
                end
            end
            ACC_RD: begin
                psum_ready_s = 1'b1;
                if (psum_valid) begin
                    psum_take_s = 1'b1;
                    cen_n_s     = 1'b0;
                    state_nxt_s = ACC_WR;
                end else begin
                    state_nxt_s = ACC_RD;
                end
            end
            ACC_WR: begin
                cen_n_s   = 1'b0;
                wen_n_s   = 1'b0;
                idx_inc_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACC_RD;
                end
            end
            DRAIN_RD: begin
                cen_n_s     = 1'b0;
                state_nxt_s = DRAIN_OUT;
            end
            DRAIN_OUT: begin
                // Holding cen_n high keeps rd_data stable under backpressure.
                out_valid_s = 1'b1;
                if (out_ready) begin
                    idx_inc_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = DRAIN_RD;
                    end
                end else begin
                    state_nxt_s = DRAIN_OUT;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Address walks base+idx and wraps at the top of the SRAM.
    always_comb begin
        if ((state_r == IDLE) || (state_r == DONE)) begin
            sram.ps_sram_addr = {AW{1'b0}};
        end else begin
            sram.ps_sram_addr = base_r + idx_r;
        end
    end

    // Write data only carries the accumulated sum during ACC_WR.
    always_comb begin
        if (state_r == ACC_WR) begin
            sram.ps_sram_wr_data = sum_s;
        end else begin
            sram.ps_sram_wr_data = {(LANES*DW){1'b0}};
        end
    end

    // Drained data comes straight from the SRAM read port.
    always_comb begin
        if (out_valid_s) begin
            out_data = sram.ps_sram_rd_data;
        end else begin
            out_data = {(LANES*DW){1'b0}};
        end
    end

    assign sram.ps_sram_cen_n  = cen_n_s;
    assign sram.ps_sram_wen_n  = wen_n_s;
    assign sram.ps_sram_rst_en = rst_en_s;
    assign psum_ready          = psum_ready_s;
    assign out_valid           = out_valid_s;
    assign cmd_ready           = (state_r == IDLE);
    assign busy                = (state_r != IDLE);
    assign done                = (state_r == DONE);

endmodule

// File: tb/tb_psum_sram_sequencer.sv
// Randomized self-checking bench for psum_sram_sequencer. A behavioural
// SRAM sits on the bus; a separate reference array holds the expected
// SRAM contents, updated from the operation semantics.
module tb_psum_sram_sequencer;
    import psum_seq_pkg::*;

    localparam int DW    = 36;
    localparam int AW    = 12;
    localparam int LANES = 4;
    localparam int W     = LANES * DW;
    localparam longint MAXV = 64'sd34359738367;
    localparam longint MINV = -64'sd34359738368;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 2'b00;
    logic [AW-1:0]  cmd_base = 12'h000;
    logic [AW-1:0]  cmd_len_m1 = 12'h000;
    logic           psum_valid = 1'b0;
    logic           psum_ready;
    logic [W-1:0]   psum_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic           busy;
    logic           done;
`ifdef PS_SAT_EN
    logic           sat_flag;
`endif

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [W-1:0]   ref_mem [0:4095];
    logic [W-1:0]   sram_mem [0:4095];
    logic [W-1:0]   obs_out [0:7];

    always #5 clk = ~clk;

    psum_sram_sequencer_if #(.DW(DW), .AW(AW), .LANES(LANES)) sif ();

    psum_sram_sequencer #(.DW(DW), .AW(AW), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_base   (cmd_base),
        .cmd_len_m1 (cmd_len_m1),
        .psum_valid (psum_valid),
        .psum_ready (psum_ready),
        .psum_data  (psum_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sram       (sif),
`ifdef PS_SAT_EN
        .sat_flag   (sat_flag),
`endif
        .busy       (busy),
        .done       (done)
    );

    // Behavioural SRAM: synchronous write, read data registered and held.
    always @(posedge clk) begin
        if (!sif.ps_sram_cen_n) begin
            if (!sif.ps_sram_wen_n) begin
                sram_mem[sif.ps_sram_addr] <= sif.ps_sram_rst_en ? '0 : sif.ps_sram_wr_data;
            end else begin
                sif.ps_sram_rd_data <= sram_mem[sif.ps_sram_addr];
            end
        end
    end

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Reference lane add: exact integer sum, then wrap or clamp.
    function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                              output bit sat);
        logic [W-1:0] r;
        sat = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            logic signed [DW-1:0] xa;
            logic signed [DW-1:0] xb;
            longint s;
            xa = a[i*DW +: DW];
            xb = b[i*DW +: DW];
            s  = longint'(xa) + longint'(xb);
            if (s > MAXV || s < MINV) sat = 1'b1;
`ifdef PS_SAT_EN
            if (s > MAXV) s = MAXV;
            if (s < MINV) s = MINV;
`endif
            r[i*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    task automatic issue_cmd(input logic [1:0] op, input int base, input int len);
        check_val("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_base   = base[AW-1:0];
        cmd_len_m1 = len[AW-1:0];
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        #1;
        check_val({tag, "_done"}, done, 1'b1);
        check_val({tag, "_busy_done"}, busy, 1'b1);
        @(negedge clk);
        #1;
        check_val({tag, "_done_low"}, done, 1'b0);
        check_val({tag, "_busy_low"}, busy, 1'b0);
    endtask

    task automatic do_clear(input int base, input int len);
        issue_cmd(OP_CLEAR, base, len);
        // A command while busy must be dropped.
        cmd_valid = 1'b1;
        cmd_op    = OP_DRAIN;
        for (int k = 0; k <= len; k++) begin
            int a;
            a = (base + k) % 4096;
            #1;
            check_val("clr_cen", sif.ps_sram_cen_n, 1'b0);
            check_val("clr_wen", sif.ps_sram_wen_n, 1'b0);
            check_val("clr_rst_en", sif.ps_sram_rst_en, 1'b1);
            check_val("clr_addr", sif.ps_sram_addr, a[AW-1:0]);
            if (k == 0) check_val("clr_cmd_ready_busy", cmd_ready, 1'b0);
            ref_mem[a] = '0;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        finish_op("clr");
    endtask

    task automatic do_acc(input int base, input int len, input logic [W-1:0] fixed, input bit rnd);
        bit exp_sat;
        exp_sat = 1'b0;
        issue_cmd(OP_ACC, base, len);
        for (int k = 0; k <= len; k++) begin
            int a;
            int gaps;
            logic [W-1:0] d;
            logic [W-1:0] e;
            bit s;
            a    = (base + k) % 4096;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                psum_valid = 1'b0;
                #1;
                check_val("acc_stall_ready", psum_ready, 1'b1);
                check_val("acc_stall_cen", sif.ps_sram_cen_n, 1'b1);
                @(negedge clk);
            end
            d = rnd ? rand_word() : fixed;
            psum_valid = 1'b1;
            psum_data  = d;
            #1;
            check_val("acc_rd_ready", psum_ready, 1'b1);
            check_val("acc_rd_cen", sif.ps_sram_cen_n, 1'b0);
            check_val("acc_rd_wen", sif.ps_sram_wen_n, 1'b1);
            check_val("acc_rd_addr", sif.ps_sram_addr, a[AW-1:0]);
            @(negedge clk);
            psum_valid = 1'b0;
            psum_data  = rand_word();
            #1;
            e = lane_add(ref_mem[a], d, s);
            exp_sat |= s;
            check_val("acc_wr_ready", psum_ready, 1'b0);
            check_val("acc_wr_cen", sif.ps_sram_cen_n, 1'b0);
            check_val("acc_wr_wen", sif.ps_sram_wen_n, 1'b0);
            check_val("acc_wr_addr", sif.ps_sram_addr, a[AW-1:0]);
            check_val("acc_wr_data", sif.ps_sram_wr_data, e);
            ref_mem[a] = e;
            @(negedge clk);
        end
`ifdef PS_SAT_EN
        #1;
        check_val("acc_sat_flag", sat_flag, exp_sat);
`endif
        finish_op("acc");
    endtask

    task automatic do_drain(input int base, input int len, input int stall);
        issue_cmd(OP_DRAIN, base, len);
        for (int k = 0; k <= len; k++) begin
            int a;
            int st;
            logic [W-1:0] first;
            a  = (base + k) % 4096;
            st = (stall < 0) ? $urandom_range(0, 3) : stall;
            psum_valid = $urandom_range(0, 1);
            #1;
            check_val("drn_rd_cen", sif.ps_sram_cen_n, 1'b0);
            check_val("drn_rd_wen", sif.ps_sram_wen_n, 1'b1);
            check_val("drn_rd_addr", sif.ps_sram_addr, a[AW-1:0]);
            check_val("drn_rd_valid", out_valid, 1'b0);
            check_val("drn_psum_ready", psum_ready, 1'b0);
            @(negedge clk);
            #1;
            first = out_data;
            if (k < 8) obs_out[k] = out_data;
            check_val("drn_out_valid", out_valid, 1'b1);
            check_val("drn_out_data", out_data, ref_mem[a]);
            for (int s = 0; s < st; s++) begin
                @(negedge clk);
                #1;
                check_val("drn_hold_valid", out_valid, 1'b1);
                check_val("drn_hold_data", out_data, first);
                check_val("drn_hold_cen", sif.ps_sram_cen_n, 1'b1);
                check_val("drn_hold_addr", sif.ps_sram_addr, a[AW-1:0]);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        psum_valid = 1'b0;
        finish_op("drn");
    endtask

    initial begin
        logic [W-1:0] plan_psum;
        logic [W-1:0] plan_exp;
        logic [W-1:0] big;
        logic [W-1:0] one;
        logic [W-1:0] ovf_exp;
        plan_psum = {36'd4, 36'd3, 36'hFFFFFFFFE, 36'd1};
        plan_exp  = {36'd12, 36'd9, 36'hFFFFFFFFA, 36'd3};
        big       = {36'd0, 36'd0, 36'd0, 36'h7FFFFFFFF};
`ifdef PS_SAT_EN
        ovf_exp   = {36'd0, 36'd0, 36'd0, 36'h7FFFFFFFF};
`else
        ovf_exp   = {36'd0, 36'd0, 36'd0, 36'h800000000};
`endif
        one       = {36'd0, 36'd0, 36'd0, 36'd1};

        // Reset values
        #1;
        check_val("rst_cen", sif.ps_sram_cen_n, 1'b1);
        check_val("rst_wen", sif.ps_sram_wen_n, 1'b1);
        check_val("rst_rst_en", sif.ps_sram_rst_en, 1'b0);
        check_val("rst_addr", sif.ps_sram_addr, 12'h000);
        check_val("rst_wr_data", sif.ps_sram_wr_data, '0);
        check_val("rst_psum_ready", psum_ready, 1'b0);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        #21;
        rst_n = 1'b1;
        @(negedge clk);

        // Full-range clear gives the reference a known starting image.
        do_clear(0, 4095);
        do_clear(16'h010, 3);

        // Three accumulation passes, then drain.
        do_clear(16'h020, 1);
        for (int p = 0; p < 3; p++) do_acc(16'h020, 1, plan_psum, 1'b0);
        do_drain(16'h020, 1, -1);
        check_val("plan_drain0", obs_out[0], plan_exp);
        check_val("plan_drain1", obs_out[1], plan_exp);

        // Range wraps from 0xFFF to 0x000.
        do_acc(16'hFFF, 1, '0, 1'b1);
        do_drain(16'hFFF, 1, 10);

        // Overflow at the positive limit.
        do_clear(16'h300, 0);
        do_acc(16'h300, 0, big, 1'b0);
        do_acc(16'h300, 0, one, 1'b0);
        do_drain(16'h300, 0, 0);
        check_val("ovf_result", obs_out[0], ovf_exp);

        // Reserved opcode: straight to DONE.
        issue_cmd(2'b11, 16'h123, 5);
        finish_op("rsv");

        // Async reset in the middle of an accumulation.
        issue_cmd(OP_ACC, 16'h100, 3);
        psum_valid = 1'b1;
        psum_data  = rand_word();
        @(negedge clk);
        psum_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", busy, 1'b0);
        check_val("arst_cen", sif.ps_sram_cen_n, 1'b1);
        check_val("arst_wen", sif.ps_sram_wen_n, 1'b1);
        check_val("arst_addr", sif.ps_sram_addr, 12'h000);
        check_val("arst_wr_data", sif.ps_sram_wr_data, '0);
        check_val("arst_psum_ready", psum_ready, 1'b0);
        check_val("arst_done", done, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check_val("arst_no_done", done, 1'b0);
            check_val("arst_idle", busy, 1'b0);
        end
        do_clear(16'h100, 3);

        // Randomized command mix.
        for (int t = 0; t < 30; t++) begin
            int op;
            int base;
            int len;
            op   = $urandom_range(0, 3);
            base = $urandom_range(0, 4095);
            len  = $urandom_range(0, 6);
            case (op)
                0: do_clear(base, len);
                1: do_acc(base, len, '0, 1'b1);
                2: do_drain(base, len, -1);
                default: begin
                    issue_cmd(2'b11, base, len);
                    finish_op("rsv_rnd");
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
